sudoku_host: RTL and testbench



---
 rtl/sudoku_host_pkg.sv | 39 +++
 rtl/sudoku_sync_fifo.sv | 48 ++++
 rtl/sudoku_host.sv | 155 +++++++++++++++
 tb/tb_sudoku_host.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_host_pkg.sv
// Shared constants, cell addressing helpers and checker state for the sudoku host.
package sudoku_host_pkg;

   localparam int CELL_W  = 4;
   localparam int CELLS   = 81;
   localparam int PUZ_W   = 324;
   localparam int NGROUPS = 27;

   typedef enum logic [1:0] {
      CHK_IDLE,
      CHK_GIVENS,
      CHK_GROUPS,
      CHK_DONE
   } chk_state_t;

   // Groups 0-8 are rows, 9-17 columns, 18-26 boxes; row0/col0 sits at the MSB.
   function automatic int cell_idx(input int group, input int k);
      int r;
      int c;
      if (group < 9) begin
         r = group;
         c = k;
      end else if (group < 18) begin
         r = k;
         c = group - 9;
      end else begin
         r = ((group - 18) / 3) * 3 + k / 3;
         c = ((group - 18) % 3) * 3 + k % 3;
      end
      return (CELLS - 1 - (r * 9 + c)) * CELL_W;
   endfunction

   function automatic logic [CELL_W-1:0] cell_of(input logic [PUZ_W-1:0] puzzle, input int idx);
      logic [8:0] off;
      off = 9'(idx);
      return puzzle[off +: CELL_W];
   endfunction

endpackage

// File: rtl/sudoku_sync_fifo.sv
// Single-clock FIFO; a push to a full queue only lands when a pop shares the edge.
module sudoku_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_push && !do_pop)      cnt <= cnt + 1'b1;
         else if (do_pop && !do_push) cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sudoku_host.sv
// Feeds puzzles to the solver over the shared bus, tracks them in issue order and
// verifies returned grids one group per cycle.
module sudoku_host
   import sudoku_host_pkg::*;
#(
   parameter int PEND_DEPTH = 4,
   parameter int OUT_DEPTH  = 8,
   parameter int RESP_DEPTH = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [PUZ_W-1:0] load_puzzle,
   output logic             load_ready,
   inout  wire  [PUZ_W-1:0] puzzle_io,
   input  logic             puzzle_oe,
   input  logic             next_puzzle,
   input  logic             solution,
   input  logic             give_up,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] giveup_cnt,
   output logic [3:0]       err_flags,
   output logic             busy
);

   logic               pend_full, pend_empty;
   logic [PUZ_W-1:0]   pend_head, issue_val;
   logic               out_full, out_empty;
   logic [PUZ_W-1:0]   out_head;
   logic               chk_full, chk_empty, chk_push, chk_pop;
   logic [2*PUZ_W-1:0] chk_head;
   logic               issue, resp, resp_ok, resp_gu;

   chk_state_t         state, state_nx;
   logic [4:0]         grp;
   logic               bad_r;
   logic [PUZ_W-1:0]   cur_ans, cur_giv;
   logic               givens_bad, group_bad;
   logic [8:0]         mask;
   logic [CELL_W-1:0]  v, gv, av;
   logic               inc_pass, inc_fail;

   assign issue      = next_puzzle && !puzzle_oe;
   assign resp       = puzzle_oe;
   assign resp_ok    = resp && !out_empty;
   assign resp_gu    = resp_ok && !(solution && !give_up);
   assign chk_push   = resp_ok && solution && !give_up;
   assign issue_val  = pend_empty ? '0 : pend_head;
   assign load_ready = !pend_full;
   assign puzzle_io  = puzzle_oe ? 'z : issue_val;

   sudoku_sync_fifo #(.WIDTH(PUZ_W), .DEPTH(PEND_DEPTH)) u_pend (
      .clk(clk), .rst(rst), .push(load_valid && load_ready), .pop(issue),
      .din(load_puzzle), .full(pend_full), .empty(pend_empty), .head(pend_head));

   sudoku_sync_fifo #(.WIDTH(PUZ_W), .DEPTH(OUT_DEPTH)) u_out (
      .clk(clk), .rst(rst), .push(issue && !out_full), .pop(resp_ok),
      .din(issue_val), .full(out_full), .empty(out_empty), .head(out_head));

   // Entry layout: answer in the upper half, original givens in the lower half.
   sudoku_sync_fifo #(.WIDTH(2*PUZ_W), .DEPTH(RESP_DEPTH)) u_chk (
      .clk(clk), .rst(rst), .push(chk_push), .pop(chk_pop),
      .din({puzzle_io, out_head}), .full(chk_full), .empty(chk_empty), .head(chk_head));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= CHK_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         CHK_IDLE:   if (!chk_empty) state_nx = CHK_GIVENS;
         CHK_GIVENS: state_nx = CHK_GROUPS;
         CHK_GROUPS: if (grp == 5'(NGROUPS - 1)) state_nx = CHK_DONE;
         default:    state_nx = CHK_IDLE;
      endcase
   end

   always_comb begin
      chk_pop  = (state == CHK_IDLE) && !chk_empty;
      inc_pass = (state == CHK_DONE) && !bad_r;
      inc_fail = (state == CHK_DONE) && bad_r;
      busy     = (state != CHK_IDLE) || !chk_empty;
   end

   always_comb begin
      givens_bad = 1'b0;
      gv = '0;
      av = '0;
      for (int c = 0; c < CELLS; c++) begin
         gv = cell_of(cur_giv, c * CELL_W);
         av = cell_of(cur_ans, c * CELL_W);
         if (gv != '0 && av != gv) givens_bad = 1'b1;
      end
   end

   // One-hot digit mask over the current group; any gap or out-of-range digit fails it.
   always_comb begin
      mask      = '0;
      group_bad = 1'b0;
      v         = '0;
      for (int k = 0; k < 9; k++) begin
         v = cell_of(cur_ans, cell_idx(int'(grp), k));
         if (v == '0 || v > 4'd9) group_bad = 1'b1;
         else                     mask = mask | (9'd1 << (v - 4'd1));
      end
      if (mask != 9'h1FF) group_bad = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grp     <= '0;
         bad_r   <= 1'b0;
         cur_ans <= '0;
         cur_giv <= '0;
      end else begin
         case (state)
            CHK_IDLE: if (chk_pop) begin
               {cur_ans, cur_giv} <= chk_head;
               bad_r <= 1'b0;
            end
            CHK_GIVENS: begin
               bad_r <= givens_bad;
               grp   <= '0;
            end
            CHK_GROUPS: begin
               bad_r <= bad_r | group_bad;
               grp   <= grp + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         giveup_cnt <= '0;
         err_flags  <= '0;
      end else begin
         if (inc_pass && pass_cnt != '1)   pass_cnt   <= pass_cnt + 1'b1;
         if (inc_fail && fail_cnt != '1)   fail_cnt   <= fail_cnt + 1'b1;
         if (resp_gu && giveup_cnt != '1)  giveup_cnt <= giveup_cnt + 1'b1;
         if (issue && pend_empty)              err_flags[0] <= 1'b1;
         if (issue && out_full)                err_flags[1] <= 1'b1;
         if (resp && out_empty)                err_flags[2] <= 1'b1;
         if (chk_push && chk_full && !chk_pop) err_flags[3] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sudoku_host.sv
// Directed bench for sudoku_host: issue/response flow, checker verdicts, errors and reset.
module tb_sudoku_host;
   import sudoku_host_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             load_valid = 1'b0;
   logic [PUZ_W-1:0] load_puzzle = '0;
   logic             load_ready;
   wire  [PUZ_W-1:0] puzzle_io;
   logic [PUZ_W-1:0] tb_drv = '0;
   logic             puzzle_oe = 1'b0;
   logic             next_puzzle = 1'b0;
   logic             solution = 1'b0;
   logic             give_up = 1'b0;
   logic [15:0]      pass_cnt, fail_cnt, giveup_cnt;
   logic [3:0]       err_flags;
   logic             busy;

   int n_chk = 0;
   int n_err = 0;

   assign puzzle_io = puzzle_oe ? tb_drv : 'z;

   always #5 clk = ~clk;

   sudoku_host #(.PEND_DEPTH(4), .OUT_DEPTH(8), .RESP_DEPTH(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_puzzle(load_puzzle),
      .load_ready(load_ready), .puzzle_io(puzzle_io), .puzzle_oe(puzzle_oe),
      .next_puzzle(next_puzzle), .solution(solution), .give_up(give_up),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .giveup_cnt(giveup_cnt),
      .err_flags(err_flags), .busy(busy));

   task automatic check(input string tag, input logic [PUZ_W-1:0] act, input logic [PUZ_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Valid grid: digit = (3r + r/3 + c + sh) mod 9 + 1.
   function automatic logic [PUZ_W-1:0] mk_grid(input int sh);
      logic [PUZ_W-1:0] p;
      p = '0;
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++)
            p[(80 - (r*9 + c))*4 +: 4] = 4'((r*3 + r/3 + c + sh) % 9 + 1);
      return p;
   endfunction

   function automatic logic [PUZ_W-1:0] mk_givens(input logic [PUZ_W-1:0] g, input int sel);
      logic [PUZ_W-1:0] p;
      p = '0;
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++)
            if ((sel == 0) ? ((r + c) % 3 == 0) : (c % 2 == 0))
               p[(80 - (r*9 + c))*4 +: 4] = g[(80 - (r*9 + c))*4 +: 4];
      return p;
   endfunction

   function automatic logic [PUZ_W-1:0] set_cell(input logic [PUZ_W-1:0] g, input int r, input int c,
                                                 input logic [3:0] v);
      logic [PUZ_W-1:0] p;
      p = g;
      p[(80 - (r*9 + c))*4 +: 4] = v;
      return p;
   endfunction

   task automatic load(input logic [PUZ_W-1:0] p);
      load_valid = 1'b1;
      load_puzzle = p;
      step();
      load_valid = 1'b0;
   endtask

   task automatic issue();
      next_puzzle = 1'b1;
      step();
      next_puzzle = 1'b0;
   endtask

   task automatic respond(input logic [PUZ_W-1:0] ans, input logic s, input logic g);
      tb_drv = ans;
      puzzle_oe = 1'b1;
      solution = s;
      give_up = g;
      step();
      puzzle_oe = 1'b0;
      solution = 1'b0;
      give_up = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (!busy) break;
         step();
      end
      check("idle_timeout", busy, 1'b0);
   endtask

   logic [PUZ_W-1:0] sol_a, sol_b, giv_a, giv_b;
   int n;

   initial begin
      sol_a = mk_grid(0);
      sol_b = mk_grid(4);
      giv_a = mk_givens(sol_a, 0);
      giv_b = mk_givens(sol_b, 1);

      step();
      step();
      check("rst_ready", load_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_pass", pass_cnt, 0);
      check("rst_err", err_flags, 0);
      check("rst_bus", puzzle_io, '0);
      rst = 1'b0;
      step();

      // two good solutions
      load(giv_a);
      load(giv_b);
      check("bus_head", puzzle_io, giv_a);
      issue();
      issue();
      check("bus_empty", puzzle_io, '0);
      respond(sol_a, 1'b1, 1'b0);
      respond(sol_b, 1'b1, 1'b0);
      wait_idle();
      check("t1_pass", pass_cnt, 2);
      check("t1_fail", fail_cnt, 0);

      // given at row0/col0 overwritten; also measures check latency
      load(giv_a);
      issue();
      respond(set_cell(sol_a, 0, 0, 4'd2), 1'b1, 1'b0);
      check("t2_busy", busy, 1'b1);
      n = 0;
      while (fail_cnt == 0 && n < 100) begin
         step();
         n++;
      end
      check("latency", n, 30);
      check("t2_fail", fail_cnt, 1);
      wait_idle();

      // duplicate 5 in column 3, no givens
      load('0);
      issue();
      respond(set_cell(sol_a, 1, 3, 4'd5), 1'b1, 1'b0);
      wait_idle();
      check("t3_fail", fail_cnt, 2);
      check("t3_pass", pass_cnt, 2);

      // underrun issues an all-zero puzzle
      check("t4_bus", puzzle_io, '0);
      issue();
      check("t4_err", err_flags, 4'b0001);
      respond(sol_b, 1'b1, 1'b0);
      wait_idle();
      check("t4_pass", pass_cnt, 3);

      // give-up paths
      respond(sol_a, 1'b0, 1'b1);
      check("t5_err", err_flags, 4'b0101);
      check("t5_gu0", giveup_cnt, 0);
      load(giv_a); issue(); respond(sol_a, 1'b0, 1'b1);
      check("t5_gu1", giveup_cnt, 1);
      load(giv_a); issue(); respond(sol_a, 1'b0, 1'b0);
      check("t5_gu2", giveup_cnt, 2);
      load(giv_a); issue(); respond(sol_a, 1'b1, 1'b1);
      check("t5_gu3", giveup_cnt, 3);
      check("t5_nochk", busy, 1'b0);
      check("t5_pass", pass_cnt, 3);

      // outstanding overflow: 9 issues into depth 8, then drain with give-ups
      for (int i = 0; i < 9; i++) issue();
      check("t6_err", err_flags, 4'b0111);
      for (int i = 0; i < 8; i++) respond(sol_a, 1'b0, 1'b1);
      check("t6_gu", giveup_cnt, 11);
      check("t6_err2", err_flags, 4'b0111);

      // check-queue overflow while the checker is mid-check
      for (int i = 0; i < 4; i++) load(giv_a);
      check("t7_full", load_ready, 1'b0);
      for (int i = 0; i < 4; i++) issue();
      check("t7_ready", load_ready, 1'b1);
      respond(sol_a, 1'b1, 1'b0);
      step(); step(); step();
      respond(sol_a, 1'b1, 1'b0);
      respond(sol_a, 1'b1, 1'b0);
      respond(sol_a, 1'b1, 1'b0);
      check("t7_err", err_flags, 4'b1111);
      wait_idle();
      check("t7_pass", pass_cnt, 6);
      check("t7_fail", fail_cnt, 2);

      // async reset in the middle of GROUPS
      load(giv_a);
      issue();
      respond(sol_a, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step();
      check("t8_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("t8_pass", pass_cnt, 0);
      check("t8_fail", fail_cnt, 0);
      check("t8_gu", giveup_cnt, 0);
      check("t8_err", err_flags, 0);
      check("t8_busy0", busy, 1'b0);
      check("t8_ready", load_ready, 1'b1);
      step();
      rst = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
